// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types.
// - lc3b_control_word: decoded control bits carried down the pipe from ID/EX.
// - mem_state_e: data-memory access state of the EX/MEM stage.
// - WMASK_*: byte-enable patterns for word and byte stores.
package lc3b_types;

  typedef struct packed {
    logic mem_read;      // instruction loads from data memory
    logic mem_write;     // instruction stores to data memory
    logic byte_op;       // LDB/STB: single-byte access
    logic load_regfile;  // instruction writes a destination register
  } lc3b_control_word;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] WMASK_WORD = 2'b11;
  localparam logic [1:0] WMASK_LO   = 2'b01;
  localparam logic [1:0] WMASK_HI   = 2'b10;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for the data-memory port.
// Ports:
//   byte_op    in   1   access is a single byte
//   addr       in  16   effective address from the ALU
//   store_data in  16   register value to store
//   rdata      in  16   raw word returned by memory
//   mem_addr   out 16   address presented to memory (word-aligned for word ops)
//   wmask      out  2   byte enables
//   wdata      out 16   store data replicated into the addressed lane
//   load_value out 16   loaded value, byte loads zero-extended
module mem_align
  import lc3b_types::*;
(
  input  logic        byte_op,
  input  logic [15:0] addr,
  input  logic [15:0] store_data,
  input  logic [15:0] rdata,
  output logic [15:0] mem_addr,
  output logic [1:0]  wmask,
  output logic [15:0] wdata,
  output logic [15:0] load_value
);

  always_comb begin
    mem_addr   = {addr[15:1], 1'b0};
    wmask      = WMASK_WORD;
    wdata      = store_data;
    load_value = rdata;
    if (byte_op) begin
      mem_addr   = addr;
      wmask      = addr[0] ? WMASK_HI : WMASK_LO;
      // Byte goes to both lanes; the mask selects which one memory keeps.
      wdata      = {store_data[7:0], store_data[7:0]};
      load_value = addr[0] ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage with data-memory access and MEM/WB output register.
// Captures execute results, issues load/store requests, stalls upstream while
// an access is outstanding and retires results to writeback.
// Ports:
//   clk, reset                      clock, async active-high reset
//   ex_valid/ex_ctrl/ex_alu/...     execute results from ID/EX
//   flush                           squash the instruction captured this cycle
//   stall_out                       hold upstream registers
//   mem_*                           data-memory request/response port
//   wb_*                            MEM/WB register to writeback
//   mem_busy                        FSM state is WAIT (debug/state view)
//   stall_cycles                    saturating count of stalled cycles
// Handshake: a request (mem_read or mem_write) stays high with stable
// address/data/mask until the memory pulses mem_resp for one cycle; the
// access completes on the edge that samples mem_resp high, which may be the
// same cycle the request first appears (zero wait states, no stall).
module ex_mem_stage
  import lc3b_types::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_valid,
  input  lc3b_control_word       ex_ctrl,
  input  logic [15:0]            ex_alu,
  input  logic [15:0]            ex_wdata,
  input  logic [2:0]             ex_dest,
  input  logic [15:0]            ex_pc_plus2,
  input  logic                   flush,
  output logic                   stall_out,
  output logic [15:0]            mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [1:0]             mem_wmask,
  output logic [15:0]            mem_wdata,
  input  logic [15:0]            mem_rdata,
  input  logic                   mem_resp,
  output logic                   wb_valid,
  output logic [15:0]            wb_data,
  output logic [2:0]             wb_dest,
  output logic                   wb_regwrite,
  output logic [15:0]            wb_pc_plus2,
  output logic                   mem_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // EX/MEM register
  logic             s_valid;
  lc3b_control_word s_ctrl;
  logic [15:0]      s_alu;
  logic [15:0]      s_wdata;
  logic [2:0]       s_dest;
  logic [15:0]      s_pc_plus2;

  mem_state_e  state, state_next;
  logic [15:0] load_value;
  logic        mem_req;

  mem_align u_align (
    .byte_op    (s_ctrl.byte_op),
    .addr       (s_alu),
    .store_data (s_wdata),
    .rdata      (mem_rdata),
    .mem_addr   (mem_address),
    .wmask      (mem_wmask),
    .wdata      (mem_wdata),
    .load_value (load_value)
  );

  // Write wins if a malformed control word sets both bits.
  assign mem_write = s_valid & s_ctrl.mem_write;
  assign mem_read  = s_valid & s_ctrl.mem_read & ~s_ctrl.mem_write;
  assign mem_req   = mem_read | mem_write;
  assign stall_out = mem_req & ~mem_resp;
  assign mem_busy  = (state == MEM_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid    <= 1'b0;
      s_ctrl     <= '0;
      s_alu      <= '0;
      s_wdata    <= '0;
      s_dest     <= '0;
      s_pc_plus2 <= '0;
    end else if (!stall_out) begin
      s_valid    <= ex_valid & ~flush;
      s_ctrl     <= ex_ctrl;
      s_alu      <= ex_alu;
      s_wdata    <= ex_wdata;
      s_dest     <= ex_dest;
      s_pc_plus2 <= ex_pc_plus2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MEM_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MEM_IDLE: if (mem_req && !mem_resp) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_resp)             state_next = MEM_IDLE;
      default:                            state_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_dest     <= '0;
      wb_regwrite <= 1'b0;
      wb_pc_plus2 <= '0;
    end else if (!stall_out) begin
      wb_valid    <= s_valid;
      wb_dest     <= s_dest;
      wb_pc_plus2 <= s_pc_plus2;
      wb_regwrite <= s_valid & s_ctrl.load_regfile;
      wb_data     <= s_ctrl.mem_read ? load_value : s_alu;
    end else begin
      // Bubble into writeback; data fields hold.
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              stall_cycles <= '0;
    else if (stall_out && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
